pim_matrix_loader: RTL

PIM_MATRIX_LOADER -- requirements
Module: pim_matrix_loader

---
 rtl/pim_matrix_loader_pkg.sv | 29 ++
 rtl/pim_idle_watchdog.sv | 39 +++
 rtl/pim_matrix_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pim_matrix_loader_pkg.sv
// Shared types and sizing for the PIM matrix loader.
// PIM_LOADER_B_COLMAJOR_EN makes matrix B arrive column-major.
package pim_matrix_loader_pkg;

    localparam int WIDTH       = 16;
    localparam int MATRIX_SIZE = 4;
    localparam int ELEM_COUNT  = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CNT_W       = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LAUNCH,
        WAIT_RESULT,
        ERROR
    } loader_state_t;

    // Storage slot in row-major matrix_B for the k-th B beat.
    function automatic logic [CNT_W-1:0] b_idx(input logic [CNT_W-1:0] k);
`ifdef PIM_LOADER_B_COLMAJOR_EN
        int unsigned ki;
        ki = {{(32-CNT_W){1'b0}}, k};
        return CNT_W'((ki % MATRIX_SIZE) * MATRIX_SIZE + ki / MATRIX_SIZE);
`else
        return k;
`endif
    endfunction

endpackage

// File: rtl/pim_idle_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a kick and flags the last one.
// expired is combinational in the MAX_IDLE_CYCLES-th consecutive idle cycle.
module pim_idle_watchdog #(
    parameter int MAX_IDLE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    input  logic clear,
    output logic expired
);

    localparam int IW = $clog2(MAX_IDLE_CYCLES + 1);
    localparam logic [IW-1:0] LIMIT = IW'(MAX_IDLE_CYCLES - 1);

    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;

    assign expired = enable && !kick && !clear && (idle_q == LIMIT);

    always_comb begin
        idle_d = idle_q;
        if (clear || kick) begin
            idle_d = '0;
        end else if (enable && !expired) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/pim_matrix_loader.sv
// Streams matrix A then B into holding registers and launches pim_controller.
// Build option PIM_LOADER_B_COLMAJOR_EN selects column-major B beat order.
module pim_matrix_loader
    import pim_matrix_loader_pkg::*;
#(
    parameter int MAX_IDLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] matrix_A [ELEM_COUNT],
    output logic [WIDTH-1:0] matrix_B [ELEM_COUNT],
    output logic             start,
    input  logic             result_ready,
    output logic             busy,
    output logic             load_error
);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mat_a_q [ELEM_COUNT];
    logic [WIDTH-1:0] mat_b_q [ELEM_COUNT];

    logic beat;
    logic last_elem;
    logic wr_a;
    logic wr_b;
    logic wd_en;
    logic wd_expired;

    assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat       = in_valid && in_ready;
    assign last_elem  = (cnt_q == CNT_W'(ELEM_COUNT - 1));
    assign start      = (state_q == LAUNCH);
    assign load_error = (state_q == ERROR);
    assign busy       = (state_q != LOAD_A) || (cnt_q != '0);
    assign wd_en      = (state_q == LOAD_B) || ((state_q == LOAD_A) && (cnt_q != '0));

    assign matrix_A = mat_a_q;
    assign matrix_B = mat_b_q;

    pim_idle_watchdog #(
        .MAX_IDLE_CYCLES(MAX_IDLE_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (wd_en),
        .kick   (beat),
        .clear  (!wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (beat) begin
                    if (in_last) begin
                        state_d = ERROR;
                    end else begin
                        wr_a = 1'b1;
                        if (last_elem) state_d = LOAD_B;
                    end
                end else if (wd_expired) begin
                    state_d = ERROR;
                end
            end
            LOAD_B: begin
                if (beat) begin
                    // in_last must coincide exactly with the final B element.
                    if (in_last != last_elem) begin
                        state_d = ERROR;
                    end else begin
                        wr_b = 1'b1;
                        if (last_elem) state_d = LAUNCH;
                    end
                end else if (wd_expired) begin
                    state_d = ERROR;
                end
            end
            LAUNCH:      state_d = WAIT_RESULT;
            WAIT_RESULT: if (result_ready) state_d = LOAD_A;
            ERROR:       state_d = ERROR;
            default:     state_d = ERROR;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ELEM_COUNT; i++) begin
                mat_a_q[i] <= '0;
                mat_b_q[i] <= '0;
            end
        end else begin
            if (wr_a) mat_a_q[cnt_q] <= in_data;
            if (wr_b) mat_b_q[b_idx(cnt_q)] <= in_data;
        end
    end

endmodule
